// File: rtl/spi_pkt_pkg.sv
// Shared types and constants for the SPI packet engine.
package spi_pkt_pkg;

  typedef enum logic [7:0] {
    OpEcho    = 8'h01,
    OpReverse = 8'h02,
    OpAccum   = 8'h03
  } opcode_t;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StLen   = 4'd1,
    StRecv  = 4'd2,
    StDrain = 4'd3,
    StRxck  = 4'd4,
    StHdr   = 4'd5,
    StSlen  = 4'd6,
    StSend  = 4'd7,
    StTxck  = 4'd8
  } state_t;

  localparam logic [7:0] ERR_LEN  = 8'hEE;
  localparam logic [7:0] ERR_CSUM = 8'hEC;

endpackage

// File: rtl/spi_word_buffer.sv
// Payload word store: byte-lane write enables, combinational read. Not reset.
module spi_word_buffer #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4
) (
  input  logic                    clk,
  input  logic [WORD_BYTES-1:0]   be,
  input  logic [AW-1:0]           waddr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic [8*WORD_BYTES-1:0] rdata
);

  logic [8*WORD_BYTES-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_packet_engine.sv
// Parses [opcode][length][payload] bytes, buffers words and streams a framed response.
// Define SPI_PKT_CHECKSUM_EN to add an RX checksum byte (RXCK) and a TX checksum byte (TXCK).
module spi_packet_engine
  import spi_pkt_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LEN_BYTES  = 2
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic [7:0] byte_recv,
  input  logic       valid,
  input  logic       busy,
  output logic       write,
  output logic [7:0] byte_send,
  output logic [7:0] status
);

  localparam int unsigned W    = 8 * WORD_BYTES;
  localparam int unsigned L    = 8 * LEN_BYTES;
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW   = L + $clog2(WORD_BYTES);
  localparam int unsigned CMAX = (LEN_BYTES > WORD_BYTES) ? LEN_BYTES : WORD_BYTES;
  localparam int unsigned CW   = $clog2(CMAX) + 1;

  state_t        state_q, state_d;
  logic [7:0]    op_q, op_d, hdr_q, hdr_d, byte_send_q, byte_send_d;
  logic [L-1:0]  len_q, len_d, rlen_q, rlen_d, idx_q, idx_d, len_new;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [W-1:0]  sum_q, sum_d, rd_word, word_new;
  logic          write_q, write_d, err_q, err_d, ovr_q, ovr_d, last_q, last_d;
  logic [WORD_BYTES-1:0] be;
  logic [AW-1:0] rd_addr;
  logic [7:0]    tx_byte;
  logic          tx_state, tx_fire, lane_last, len_last;

  spi_word_buffer #(
    .WORD_BYTES(WORD_BYTES),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_buf (
    .clk  (clk),
    .be   (be),
    .waddr(AW'(idx_q)),
    .wdata({WORD_BYTES{byte_recv}}),
    .raddr(rd_addr),
    .rdata(rd_word)
  );

  assign rd_addr   = (state_q == StSend && op_q == OpReverse) ? AW'(len_q - idx_q - L'(1))
                                                               : AW'(idx_q);
  assign lane_last = (bcnt_q == CW'(WORD_BYTES - 1));
  assign len_last  = (bcnt_q == CW'(LEN_BYTES - 1));
  assign tx_state  = state_q inside {StHdr, StSlen, StSend, StTxck};
  // last_q holds the FSM in its TX state while the final write pulse is out.
  assign tx_fire   = tx_state && !busy && !write_q && !last_q;

  assign write     = write_q;
  assign byte_send = byte_send_q;
  assign status    = {err_q, ovr_q, 2'b00, state_q};

`ifdef SPI_PKT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d, txck_q, txck_d;

  always_comb begin
    csum_d = csum_q;
    txck_d = txck_q;
    if (state_q == StIdle) begin
      txck_d = '0;
      if (valid) csum_d = byte_recv;
    end else if (valid && state_q inside {StLen, StRecv}) begin
      csum_d = csum_q ^ byte_recv;
    end
    if (tx_fire) txck_d = txck_q ^ tx_byte;
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      csum_q <= '0;
      txck_q <= '0;
    end else begin
      csum_q <= csum_d;
      txck_q <= txck_d;
    end
  end
`endif

  always_comb begin
    tx_byte = hdr_q;
    unique case (state_q)
      StSlen: tx_byte = rlen_q[8*bcnt_q +: 8];
      StSend: tx_byte = (op_q == OpAccum) ? sum_q[8*bcnt_q +: 8] : rd_word[8*bcnt_q +: 8];
`ifdef SPI_PKT_CHECKSUM_EN
      StTxck: tx_byte = txck_q;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    rlen_d      = rlen_q;
    hdr_d       = hdr_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    drain_d     = drain_q;
    sum_d       = sum_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
    last_d      = last_q;
    write_d     = 1'b0;
    byte_send_d = byte_send_q;
    be          = '0;
    len_new     = len_q;
    len_new[8*bcnt_q +: 8] = byte_recv;
    word_new    = rd_word;
    word_new[8*bcnt_q +: 8] = byte_recv;

    if (valid && tx_state) ovr_d = 1'b1;
    if (tx_fire) begin
      write_d     = 1'b1;
      byte_send_d = tx_byte;
    end

    if (last_q) begin
      last_d  = 1'b0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid && byte_recv inside {OpEcho, OpReverse, OpAccum}) begin
            op_d    = byte_recv;
            len_d   = '0;
            bcnt_d  = '0;
            idx_d   = '0;
            sum_d   = '0;
            state_d = StLen;
          end
        end
        StLen: begin
          if (valid) begin
            len_d  = len_new;
            bcnt_d = bcnt_q + CW'(1);
            if (len_last) begin
              bcnt_d = '0;
              hdr_d  = op_q;
              rlen_d = (op_q == OpAccum) ? L'(1) : len_new;
              if (len_new > L'(DEPTH)) begin
                drain_d = DW'(len_new) * DW'(WORD_BYTES);
                state_d = StDrain;
              end else if (len_new == '0) begin
`ifdef SPI_PKT_CHECKSUM_EN
                state_d = StRxck;
`else
                state_d = StHdr;
`endif
              end else begin
                state_d = StRecv;
              end
            end
          end
        end
        StRecv: begin
          if (valid) begin
            for (int i = 0; i < int'(WORD_BYTES); i++) be[i] = (bcnt_q == CW'(i));
            bcnt_d = bcnt_q + CW'(1);
            if (lane_last) begin
              bcnt_d = '0;
              sum_d  = sum_q + word_new;
              idx_d  = idx_q + L'(1);
              if (idx_q == len_q - L'(1)) begin
`ifdef SPI_PKT_CHECKSUM_EN
                state_d = StRxck;
`else
                state_d = StHdr;
`endif
              end
            end
          end
        end
        StDrain: begin
          if (valid) begin
            drain_d = drain_q - DW'(1);
            if (drain_q == DW'(1)) begin
              err_d   = 1'b1;
              hdr_d   = ERR_LEN;
              rlen_d  = '0;
              state_d = StHdr;
            end
          end
        end
`ifdef SPI_PKT_CHECKSUM_EN
        StRxck: begin
          if (valid) begin
            if (byte_recv != csum_q) begin
              err_d  = 1'b1;
              hdr_d  = ERR_CSUM;
              rlen_d = '0;
            end
            state_d = StHdr;
          end
        end
        StTxck: if (tx_fire) last_d = 1'b1;
`endif
        StHdr: begin
          if (tx_fire) begin
            bcnt_d  = '0;
            state_d = StSlen;
          end
        end
        StSlen: begin
          if (tx_fire) begin
            bcnt_d = bcnt_q + CW'(1);
            if (len_last) begin
              bcnt_d = '0;
              idx_d  = '0;
              if (rlen_q != '0) begin
                state_d = StSend;
              end else begin
`ifdef SPI_PKT_CHECKSUM_EN
                state_d = StTxck;
`else
                last_d  = 1'b1;
`endif
              end
            end
          end
        end
        StSend: begin
          if (tx_fire) begin
            bcnt_d = bcnt_q + CW'(1);
            if (lane_last) begin
              bcnt_d = '0;
              idx_d  = idx_q + L'(1);
              if (idx_q == rlen_q - L'(1)) begin
`ifdef SPI_PKT_CHECKSUM_EN
                state_d = StTxck;
`else
                last_d  = 1'b1;
`endif
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= StIdle;
      op_q        <= '0;
      len_q       <= '0;
      rlen_q      <= '0;
      hdr_q       <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      drain_q     <= '0;
      sum_q       <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      last_q      <= 1'b0;
      write_q     <= 1'b0;
      byte_send_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      rlen_q      <= rlen_d;
      hdr_q       <= hdr_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      drain_q     <= drain_d;
      sum_q       <= sum_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      last_q      <= last_d;
      write_q     <= write_d;
      byte_send_q <= byte_send_d;
    end
  end

endmodule

// File: tb/tb_spi_packet_engine.sv
// Self-checking bench for spi_packet_engine: directed and random packets against a queue model.
module tb_spi_packet_engine;

  localparam int unsigned WB    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LB    = 2;

  logic       clk = 1'b0;
  logic       rst_L, valid, busy, write;
  logic [7:0] byte_recv, byte_send, status;

  always #5 clk = ~clk;

  spi_packet_engine #(
    .WORD_BYTES(WB),
    .DEPTH     (DEPTH),
    .LEN_BYTES (LB)
  ) dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .byte_recv(byte_recv),
    .valid    (valid),
    .busy     (busy),
    .write    (write),
    .byte_send(byte_send),
    .status   (status)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          k;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          wr_cyc[$];
  logic [31:0] wq[$];
  bit          exp_err = 1'b0;
  bit          exp_ovr = 1'b0;
  logic        prev_busy  = 1'b0;
  logic        prev_write = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every write must follow a cycle with busy and write low, and never in a receive state.
  always @(negedge clk) begin
    if (rst_L === 1'b1 && write === 1'b1) begin
      check("tx_legal", {61'd0, prev_busy, prev_write, status[3:0] < 4'd4}, 64'd0);
      rx_q.push_back(byte_send);
      wr_cyc.push_back(cyc);
    end
    prev_busy  <= busy;
    prev_write <= write;
  end

  function automatic void build_expected(input logic [7:0] op, input bit bad_ck);
    int          len = wq.size();
    logic [31:0] body[$];
    logic [31:0] s = '0;
    logic [7:0]  hdr;
    int          rlen;
    exp_q.delete();
    if (len > int'(DEPTH)) begin
      hdr = 8'hEE;
      exp_err = 1'b1;
    end else if (bad_ck) begin
      hdr = 8'hEC;
      exp_err = 1'b1;
    end else begin
      hdr = op;
      if (op == 8'h01) body = wq;
      else if (op == 8'h02) for (int i = len - 1; i >= 0; i--) body.push_back(wq[i]);
      else begin
        foreach (wq[i]) s += wq[i];
        body.push_back(s);
      end
    end
    rlen = body.size();
    exp_q.push_back(hdr);
    for (int i = 0; i < int'(LB); i++) exp_q.push_back(8'((rlen >> (8 * i)) & 255));
    foreach (body[i]) for (int j = 0; j < int'(WB); j++) exp_q.push_back(body[i][8*j +: 8]);
`ifdef SPI_PKT_CHECKSUM_EN
    begin
      logic [7:0] ck = '0;
      foreach (exp_q[i]) ck ^= exp_q[i];
      exp_q.push_back(ck);
    end
`endif
  endfunction

`ifdef SPI_PKT_CHECKSUM_EN
  function automatic logic [7:0] rx_checksum(input logic [7:0] op);
    logic [7:0] ck = op;
    int         len = wq.size();
    for (int i = 0; i < int'(LB); i++) ck ^= 8'((len >> (8 * i)) & 255);
    foreach (wq[i]) for (int j = 0; j < int'(WB); j++) ck ^= wq[i][8*j +: 8];
    return ck;
  endfunction
`endif

  task automatic put_byte(input logic [7:0] b);
    valid     = 1'b1;
    byte_recv = b;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_packet(input logic [7:0] op, input bit bad_ck);
    int len = wq.size();
    build_expected(op, bad_ck);
    rx_q.delete();
    wr_cyc.delete();
    put_byte(op);
    for (int i = 0; i < int'(LB); i++) put_byte(8'((len >> (8 * i)) & 255));
    foreach (wq[i]) for (int j = 0; j < int'(WB); j++) put_byte(wq[i][8*j +: 8]);
`ifdef SPI_PKT_CHECKSUM_EN
    if (len <= int'(DEPTH)) put_byte(bad_ck ? ~rx_checksum(op) : rx_checksum(op));
`endif
  endtask

  task automatic wait_response(input string tag, input bit rb);
    int n;
    for (n = 0; n < 3000; n++) begin
      if (status[3:0] == 4'd0 && rx_q.size() >= exp_q.size()) break;
      @(posedge clk); #1;
      busy = rb ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    busy = 1'b0;
    check({tag, "_done"}, 64'(n < 3000), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_byte"}, 64'(rx_q[i]), 64'(exp_q[i]));
    check({tag, "_flags"}, 64'(status[7:6]), 64'({exp_err, exp_ovr}));
  endtask

  task automatic rand_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_L = 1'b0; valid = 1'b0; busy = 1'b0; byte_recv = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_write", 64'(write), 64'd0);
    check("rst_byte_send", 64'(byte_send), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    rst_L = 1'b1;
    @(posedge clk); #1;

    // 1: ECHO, two words, busy low: writes every second cycle
    wq.delete(); wq.push_back(32'h11223344); wq.push_back(32'hAABBCCDD);
    send_packet(8'h01, 1'b0);
    wait_response("t1_echo", 1'b0);
    for (int i = 1; i < wr_cyc.size(); i++)
      check("t1_spacing", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd2);

    // 2: REVERSE 1,2,3
    wq.delete(); wq.push_back(32'd1); wq.push_back(32'd2); wq.push_back(32'd3);
    send_packet(8'h02, 1'b0);
    wait_response("t2_reverse", 1'b0);

    // 3: ACCUM with wrap
    wq.delete(); wq.push_back(32'hFFFFFFFF); wq.push_back(32'h00000002);
    send_packet(8'h03, 1'b0);
    wait_response("t3_accum", 1'b0);

    // Random packets with junk bytes in IDLE and random busy
    for (int p = 0; p < 12; p++) begin
      int len;
      repeat ($urandom_range(0, 2)) put_byte(8'($urandom_range(4, 255)));
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(17, 19) : $urandom_range(0, 16);
      rand_words(len);
      send_packet(8'($urandom_range(1, 3)), 1'b0);
      wait_response("rand", 1'($urandom_range(0, 1)));
    end

    // 4: oversize length drains then errors; next packet is normal
    rand_words(17);
    send_packet(8'h01, 1'b0);
    wait_response("t4_drain", 1'b0);
    rand_words(2);
    send_packet(8'h01, 1'b0);
    wait_response("t4_after", 1'b0);

    // 5: busy held mid-SEND; valid during SEND sets rx_overrun
    rand_words(8);
    send_packet(8'h01, 1'b0);
    for (k = 0; k < 500; k++) begin
      if (status[3:0] == 4'd7) break;
      @(posedge clk); #1;
    end
    check("t5_reach_send", 64'(k < 500), 64'd1);
    busy = 1'b1;
    valid = 1'b1;
    byte_recv = 8'($urandom);
    @(posedge clk); #1;
    valid = 1'b0;
    exp_ovr = 1'b1;
    @(negedge clk);
    k = rx_q.size();
    repeat (20) @(posedge clk);
    #1;
    check("t5_hold", 64'(rx_q.size()), 64'(k));
    busy = 1'b0;
    wait_response("t5_busy", 1'b0);

    // 6: reset mid-RECV aborts; a fresh ECHO works
    put_byte(8'h01); put_byte(8'h03); put_byte(8'h00); put_byte(8'hAB); put_byte(8'hCD);
    check("t6_in_recv", 64'(status[3:0]), 64'd2);
    #2 rst_L = 1'b0;
    #1;
    check("t6_rst_write", 64'(write), 64'd0);
    check("t6_rst_status", 64'(status), 64'd0);
    @(posedge clk); #1;
    rst_L = 1'b1;
    exp_err = 1'b0;
    exp_ovr = 1'b0;
    @(posedge clk); #1;
    rand_words(1);
    send_packet(8'h01, 1'b0);
    wait_response("t6_fresh", 1'b0);

`ifdef SPI_PKT_CHECKSUM_EN
    rand_words(1);
    send_packet(8'h01, 1'b1);
    wait_response("t6_bad_ck", 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
